lcd_read_ctrl: RTL and testbench

//  HD44780 bus reader: the read direction of the 8-bit LCD interface whose write side drives
//  DB_out (init/reset commands, DDRAM address 0xC0, 16 counter characters).
//  - Generates RS/RW/E timing for one instruction-register read (busy flag + address counter)
//    or one data-RAM read, and samples DB[7:0].
//  - Optional busy-poll mode repeats the read until BF=0 or a poll limit, so the write

---
 rtl/lcd_read_ctrl.sv | 109 ++++++++++
 tb/tb_lcd_read_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl: HD44780 bus reader generating RS/RW/E read timing, sampling DB, with optional busy-flag polling
module lcd_read_ctrl #(
  parameter int T_AS     = 2,
  parameter int T_EH     = 25,
  parameter int T_EL     = 25,
  parameter int POLL_MAX = 4095
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       poll_busy,
  input  logic [7:0] db_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       lcd_db_oe,
  output logic [7:0] rd_data,
  output logic       rd_done,
  output logic       busy_timeout,
  output logic       idle
);
  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, E_LOW, DONE} state_t;
  localparam logic [15:0] AS_L = 16'(T_AS - 1);
  localparam logic [15:0] EH_L = 16'(T_EH - 1);
  localparam logic [15:0] EL_L = 16'(T_EL - 1);
  localparam logic [11:0] PMAX = 12'(POLL_MAX);
  state_t      state;
  logic [15:0] cnt;
  logic [11:0] pcnt;
  logic        poll_q;
  // Read sequencer; every output is registered alongside the state it belongs to
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pcnt         <= '0;
      poll_q       <= 1'b0;
      lcd_rs       <= 1'b0;
      lcd_rw       <= 1'b0;
      lcd_e        <= 1'b0;
      lcd_db_oe    <= 1'b0;
      rd_data      <= 8'h00;
      rd_done      <= 1'b0;
      busy_timeout <= 1'b0;
      idle         <= 1'b1;
    end else begin
      rd_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            poll_q       <= poll_busy;
            busy_timeout <= 1'b0;
            pcnt         <= '0;
            cnt          <= '0;
            lcd_db_oe    <= 1'b0;
            lcd_rw       <= 1'b1;
            lcd_rs       <= rd_rs;
            idle         <= 1'b0;
            state        <= SETUP;
          end else begin
            lcd_db_oe <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == AS_L) begin
            cnt   <= '0;
            lcd_e <= 1'b1;
            state <= E_HIGH;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        E_HIGH: begin
          if (cnt == EH_L) begin
            cnt     <= '0;
            rd_data <= db_in;
            lcd_e   <= 1'b0;
            state   <= E_LOW;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        E_LOW: begin
          if (cnt == EL_L) begin
            cnt <= '0;
            if (poll_q && rd_data[7] && pcnt != PMAX) begin
              pcnt  <= pcnt + 12'd1;
              state <= SETUP;
            end else begin
              busy_timeout <= poll_q && rd_data[7];
              rd_done      <= 1'b1;
              lcd_rw       <= 1'b0;
              lcd_rs       <= 1'b0;
              state        <= DONE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          idle  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_read_ctrl.sv
// tb_lcd_read_ctrl: directed scoreboard bench for lcd_read_ctrl (default instance plus a POLL_MAX=2 instance)
module tb_lcd_read_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic rd_req = 1'b0, rd_rs = 1'b0, poll_busy = 1'b0;
  logic rd_req2 = 1'b0, rd_rs2 = 1'b0, poll2 = 1'b0;
  logic [7:0] db_in = 8'h00;
  logic lcd_rs, lcd_rw, lcd_e, lcd_db_oe, rd_done, busy_timeout, idle;
  logic lcd_rs2, lcd_rw2, lcd_e2, lcd_db_oe2, rd_done2, busy_timeout2, idle2;
  logic [7:0] rd_data, rd_data2;
  int cyc = 0, checks = 0, failures = 0, c0 = 0, bad = 0;
  typedef struct {logic [7:0] d; logic to; int c; int p;} exp_t;
  exp_t q1[$], q2[$];
  exp_t e1, e2;

  lcd_read_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_rs(rd_rs), .poll_busy(poll_busy), .db_in(db_in),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db_oe(lcd_db_oe), .rd_data(rd_data),
    .rd_done(rd_done), .busy_timeout(busy_timeout), .idle(idle)
  );

  lcd_read_ctrl #(.POLL_MAX(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req2), .rd_rs(rd_rs2), .poll_busy(poll2), .db_in(db_in),
    .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2), .lcd_e(lcd_e2), .lcd_db_oe(lcd_db_oe2), .rd_data(rd_data2),
    .rd_done(rd_done2), .busy_timeout(busy_timeout2), .idle(idle2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic wait_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg_at(int c);
    wait_to(c);
    @(negedge clk);
  endtask

  int pc1 = 0, pc2 = 0;
  logic pe1 = 1'b0, pe2 = 1'b0;
  // Monitor: pop an expectation whenever either instance reports rd_done
  always @(negedge clk) begin
    if (!rst_n) begin
      pc1 = 0;
      pc2 = 0;
    end else begin
      if (lcd_e && !pe1) pc1++;
      if (lcd_e2 && !pe2) pc2++;
    end
    pe1 = lcd_e;
    pe2 = lcd_e2;
    if (rd_done) begin
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("done_cycle1", cyc, e1.c);
        chk("rd_data1", int'(rd_data), int'(e1.d));
        chk("timeout1", int'(busy_timeout), int'(e1.to));
        chk("pulses1", pc1, e1.p);
      end
      pc1 = 0;
    end
    if (rd_done2) begin
      if (q2.size() == 0) chk("unexpected_done2", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("done_cycle2", cyc, e2.c);
        chk("rd_data2", int'(rd_data2), int'(e2.d));
        chk("timeout2", int'(busy_timeout2), int'(e2.to));
        chk("pulses2", pc2, e2.p);
      end
      pc2 = 0;
    end
  end

  logic prs1 = 1'b0, prw1 = 1'b0, ppe1 = 1'b0, prs2 = 1'b0, prw2 = 1'b0, ppe2 = 1'b0;
  // Bus invariants: no FPGA drive during a read, RS/RW frozen while E is high
  always @(negedge clk) begin
    chk("oe_excl1", int'(lcd_db_oe & (lcd_rw | lcd_e)), 0);
    chk("oe_excl2", int'(lcd_db_oe2 & (lcd_rw2 | lcd_e2)), 0);
    if (lcd_e && ppe1) chk("rsrw_stable1", int'({lcd_rs, lcd_rw}), int'({prs1, prw1}));
    if (lcd_e2 && ppe2) chk("rsrw_stable2", int'({lcd_rs2, lcd_rw2}), int'({prs2, prw2}));
    {prs1, prw1, ppe1} = {lcd_rs, lcd_rw, lcd_e};
    {prs2, prw2, ppe2} = {lcd_rs2, lcd_rw2, lcd_e2};
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    neg_at(2);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_e", lcd_e, 0);
    chk("rst_oe", lcd_db_oe, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_to", busy_timeout, 0);
    chk("rst_idle", idle, 1);
    wait_to(3);
    rst_n = 1'b1;
    // 1: plain IR read
    wait_to(cyc + 3);
    db_in = 8'h45; rd_rs = 1'b0; poll_busy = 1'b0; rd_req = 1'b1; c0 = cyc;
    q1.push_back('{8'h45, 1'b0, c0 + 53, 1});
    wait_to(c0 + 1);
    rd_req = 1'b0;
    neg_at(c0 + 2);
    chk("t1_setup_e", lcd_e, 0);
    chk("t1_setup_rw", lcd_rw, 1);
    chk("t1_setup_oe", lcd_db_oe, 0);
    chk("t1_setup_rs", lcd_rs, 0);
    neg_at(c0 + 3);  chk("t1_e_first", lcd_e, 1);
    neg_at(c0 + 27); chk("t1_e_last", lcd_e, 1);
    neg_at(c0 + 28); chk("t1_e_low", lcd_e, 0);
    neg_at(c0 + 53); chk("t1_done_oe", lcd_db_oe, 0); chk("t1_done_idle", idle, 0); chk("t1_done_rw", lcd_rw, 0);
    neg_at(c0 + 54); chk("t1_idle1_oe", lcd_db_oe, 0); chk("t1_idle1_idle", idle, 1);
    neg_at(c0 + 55); chk("t1_idle2_oe", lcd_db_oe, 1);
    // 2: poll, busy for three reads then ready
    wait_to(cyc + 3);
    db_in = 8'hC0; poll_busy = 1'b1; rd_req = 1'b1; c0 = cyc;
    q1.push_back('{8'h40, 1'b0, c0 + 209, 4});
    wait_to(c0 + 1);
    rd_req = 1'b0; poll_busy = 1'b0;
    wait_to(c0 + 140);
    db_in = 8'h40;
    neg_at(c0 + 212);
    // 3: poll timeout on the POLL_MAX=2 instance, then cleared by the next request
    wait_to(cyc + 3);
    db_in = 8'h80; poll2 = 1'b1; rd_req2 = 1'b1; c0 = cyc;
    q2.push_back('{8'h80, 1'b1, c0 + 157, 3});
    wait_to(c0 + 1);
    rd_req2 = 1'b0; poll2 = 1'b0;
    neg_at(c0 + 160);
    chk("t3_to_held", busy_timeout2, 1);
    chk("t3_idle", idle2, 1);
    wait_to(c0 + 161);
    db_in = 8'h45; rd_req2 = 1'b1; c0 = cyc;
    q2.push_back('{8'h45, 1'b0, c0 + 53, 1});
    neg_at(c0 + 1);
    chk("t3_to_cleared", busy_timeout2, 0);
    wait_to(c0 + 1);
    rd_req2 = 1'b0;
    neg_at(c0 + 56);
    // 4: data read with a stray request during E high
    wait_to(cyc + 3);
    db_in = 8'h31; rd_rs = 1'b1; rd_req = 1'b1; c0 = cyc;
    q1.push_back('{8'h31, 1'b0, c0 + 53, 1});
    bad = 0;
    for (int k = 1; k <= 52; k++) begin
      wait_to(c0 + k);
      rd_req = (k == 10);
      rd_rs = 1'b0;
      @(negedge clk);
      if (!lcd_rs) bad++;
    end
    rd_req = 1'b0;
    chk("t4_rs_held", bad, 0);
    neg_at(c0 + 53); chk("t4_done_rs", lcd_rs, 0);
    neg_at(c0 + 60); chk("t4_no_requeue_idle", idle, 1); chk("t4_no_requeue_rw", lcd_rw, 0);
    // 5: reset during E high
    wait_to(cyc + 3);
    db_in = 8'h45; rd_req = 1'b1; c0 = cyc;
    wait_to(c0 + 1);
    rd_req = 1'b0;
    neg_at(c0 + 10); chk("t5_in_e_high", lcd_e, 1);
    wait_to(c0 + 10);
    rst_n = 1'b0;
    wait_to(c0 + 11);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_e", lcd_e, 0);
    chk("t5_rw", lcd_rw, 0);
    chk("t5_oe_first", lcd_db_oe, 0);
    chk("t5_idle", idle, 1);
    chk("t5_done", rd_done, 0);
    neg_at(c0 + 12); chk("t5_oe_second", lcd_db_oe, 1);
    neg_at(c0 + 70);
    for (int i = 0; i < 200 && (q1.size() + q2.size()) != 0; i++) @(posedge clk);
    chk("queues_drained", q1.size() + q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
